// File: rtl/deserializer.sv
// rtl/deserializer.sv - collects DEPTH serial elements into one parallel word, valid/ready both sides
// Optional zero-padded partial-word flush enabled by DESERIALIZER_FLUSH_EN

module deserializer #(
   parameter int ELEM_WIDTH = 4,
   parameter int DEPTH      = 8
) (
   input  logic                              clk_i,
   input  logic                              srst,
   input  logic                              l_shift,
   input  logic                              flush,
   input  logic [ELEM_WIDTH-1:0]             si,
   input  logic                              si_valid,
   output logic                              si_ready,
   output logic [DEPTH-1:0][ELEM_WIDTH-1:0]  po,
   output logic [$clog2(DEPTH+1)-1:0]        po_count,
   output logic                              po_valid,
   input  logic                              po_ready
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH-1);
   localparam logic [IW-1:0] TOP  = IW'(DEPTH-1);

   logic [DEPTH-1:0][ELEM_WIDTH-1:0] acc, acc_next;
   logic [CW-1:0] cnt, cnt_after, hold_n;
   logic [IW-1:0] wpos;
   logic ord, ord_eff, accept, out_free, holding;
   logic full_done, flush_done, done;

   // cnt == DEPTH doubles as the HOLD marker: a completed word waits in acc
   assign holding   = (cnt == FULL);
   assign si_ready  = !holding;
   assign accept    = si_valid && si_ready;
   assign out_free  = !po_valid || po_ready;
   assign ord_eff   = (cnt == '0) ? l_shift : ord;
   assign wpos      = ord_eff ? (TOP - IW'(cnt)) : IW'(cnt);
   assign cnt_after = cnt + CW'(accept);
   assign full_done = accept && (cnt == LAST);

`ifdef DESERIALIZER_FLUSH_EN
   assign flush_done = flush && !holding && (cnt_after != '0);
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign flush_done   = 1'b0;
`endif

   assign done = full_done || flush_done;

   always_comb begin
      acc_next = acc;
      if (accept)
         acc_next[wpos] = si;
   end

   always_ff @(posedge clk_i) begin
      if (srst) begin
         acc      <= '0;
         cnt      <= '0;
         hold_n   <= '0;
         ord      <= 1'b0;
         po       <= '0;
         po_count <= '0;
         po_valid <= 1'b0;
      end else begin
         if (po_valid && po_ready)
            po_valid <= 1'b0;

         if (holding) begin
            if (out_free) begin
               po       <= acc;
               po_count <= hold_n;
               po_valid <= 1'b1;
               acc      <= '0;
               cnt      <= '0;
            end
         end else if (done) begin
            if (out_free) begin
               po       <= acc_next;
               po_count <= cnt_after;
               po_valid <= 1'b1;
               acc      <= '0;
               cnt      <= '0;
            end else begin
               acc    <= acc_next;
               hold_n <= cnt_after;
               cnt    <= FULL;
            end
         end else if (accept) begin
            acc <= acc_next;
            cnt <= cnt_after;
         end

         if (accept && (cnt == '0))
            ord <= l_shift;
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed and randomized checks of deserializer (DEPTH=4, ELEM_WIDTH=4)
// Flush expectations follow DESERIALIZER_FLUSH_EN

module tb_deserializer;

   localparam int EW = 4;
   localparam int D  = 4;

   logic        clk = 1'b0;
   logic        srst, l_shift, flush, si_valid, po_ready;
   logic [3:0]  si;
   logic        si_ready, po_valid;
   logic [15:0] po;
   logic [2:0]  po_count;

   int checks = 0;
   int errors = 0;

   int exp_word[$];
   int exp_cnt[$];
   int cur[$];
   bit mord;

   always #5 clk = ~clk;

   deserializer #(.ELEM_WIDTH(EW), .DEPTH(D)) dut (
      .clk_i    (clk),
      .srst     (srst),
      .l_shift  (l_shift),
      .flush    (flush),
      .si       (si),
      .si_valid (si_valid),
      .si_ready (si_ready),
      .po       (po),
      .po_count (po_count),
      .po_valid (po_valid),
      .po_ready (po_ready)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] v);
      si       = v;
      si_valid = 1'b1;
      for (int n = 0; n < 50 && si_ready !== 1'b1; n++)
         tick;
      chk("beat_ready", si_ready, 1);
      tick;
      si_valid = 1'b0;
   endtask

   // Reference: a word is the list of collected elements, element k placed at
   // position k (ord=0) or DEPTH-1-k (ord=1), unfilled positions zero
   task automatic model_complete;
      int word = 0;
      for (int k = 0; k < cur.size(); k++) begin
         int pos = mord ? (D - 1 - k) : k;
         word = word | (cur[k] << (pos * EW));
      end
      exp_word.push_back(word);
      exp_cnt.push_back(cur.size());
      cur.delete();
   endtask

   task automatic check_out(input string tag);
      if (exp_word.size() == 0)
         chk({tag, "_unexpected"}, po_valid, 0);
      else begin
         chk({tag, "_po"}, po, exp_word.pop_front());
         chk({tag, "_cnt"}, po_count, exp_cnt.pop_front());
      end
   endtask

   initial begin
      bit          prev_stall;
      logic [15:0] prev_po;
      logic [2:0]  prev_cnt;

      srst = 1'b1; l_shift = 1'b0; flush = 1'b0; si = '0; si_valid = 1'b0; po_ready = 1'b1;

      // Reset
      tick; tick;
      srst = 1'b0;
      chk("rst_valid", po_valid, 0);
      chk("rst_po", po, 16'h0000);
      chk("rst_cnt", po_count, 0);
      chk("rst_ready", si_ready, 1);

      // Right fill, back-to-back words
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) chk("lat_before", po_valid, 0);
         send(4'(i));
      end
      chk("w1_valid", po_valid, 1);
      chk("w1_po", po, 16'h4321);
      chk("w1_cnt", po_count, 4);
      for (int i = 5; i <= 8; i++) begin
         chk("b2b_ready", si_ready, 1);
         send(4'(i));
      end
      chk("w2_valid", po_valid, 1);
      chk("w2_po", po, 16'h8765);
      chk("w2_cnt", po_count, 4);
      tick;
      chk("w2_consumed", po_valid, 0);

      // Left fill, and l_shift change mid-word is ignored
      l_shift = 1'b1;
      for (int i = 1; i <= 4; i++) send(4'(i));
      chk("left_po", po, 16'h1234);
      tick;
      for (int i = 1; i <= 4; i++) begin
         if (i == 3) l_shift = 1'b0;
         send(4'(i));
      end
      chk("left_toggle_po", po, 16'h1234);
      tick;

      // Backpressure and HOLD
      l_shift = 1'b0; po_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(4'(i));
      chk("bp_valid", po_valid, 1);
      chk("bp_po", po, 16'h4321);
      chk("bp_ready_low", si_ready, 0);
      tick;
      chk("bp_stable_po", po, 16'h4321);
      chk("bp_still_low", si_ready, 0);
      po_ready = 1'b1;
      tick;
      chk("bp_next_valid", po_valid, 1);
      chk("bp_next_po", po, 16'h8765);
      chk("bp_ready_back", si_ready, 1);
      tick;
      chk("bp_drained", po_valid, 0);

      // Flush
      l_shift = 1'b0;
      send(4'hA); send(4'hB);
      flush = 1'b1; tick; flush = 1'b0;
`ifdef DESERIALIZER_FLUSH_EN
      chk("fl_valid", po_valid, 1);
      chk("fl_po", po, 16'h00BA);
      chk("fl_cnt", po_count, 2);
      tick;
      l_shift = 1'b1;
      send(4'hA); send(4'hB);
      flush = 1'b1; tick; flush = 1'b0;
      chk("fl_left_po", po, 16'hAB00);
      chk("fl_left_cnt", po_count, 2);
      tick;
      flush = 1'b1; tick; flush = 1'b0;
      chk("fl_empty", po_valid, 0);
      tick;
      chk("fl_empty2", po_valid, 0);
`else
      chk("fl_ignored", po_valid, 0);
      send(4'hC); send(4'hD);
      chk("fl_ign_po", po, 16'hDCBA);
      chk("fl_ign_cnt", po_count, 4);
      tick;
`endif

      // Mid-word reset discards the partial word
      l_shift = 1'b0;
      send(4'h1); send(4'h2); send(4'h3);
      srst = 1'b1; tick; srst = 1'b0;
      chk("mid_rst_valid", po_valid, 0);
      chk("mid_rst_ready", si_ready, 1);
      for (int i = 5; i <= 8; i++) send(4'(i));
      chk("mid_po", po, 16'h8765);
      chk("mid_cnt", po_count, 4);
      tick;
      chk("mid_single", po_valid, 0);

      // Randomized traffic against the reference model
      srst = 1'b1; tick; srst = 1'b0;
      exp_word.delete(); exp_cnt.delete(); cur.delete();
      prev_stall = 1'b0; prev_po = '0; prev_cnt = '0;
      for (int c = 0; c < 3000; c++) begin
         si       = 4'($urandom_range(0, 15));
         si_valid = ($urandom_range(0, 3) != 0);
         l_shift  = 1'($urandom_range(0, 1));
         flush    = ($urandom_range(0, 7) == 0);
         po_ready = ($urandom_range(0, 2) != 0);
         if (prev_stall) begin
            chk("stall_valid", po_valid, 1);
            chk("stall_po", po, prev_po);
            chk("stall_cnt", po_count, prev_cnt);
         end
         if (po_valid && po_ready)
            check_out("rand");
         prev_stall = po_valid && !po_ready;
         prev_po    = po;
         prev_cnt   = po_count;
         if (si_valid && si_ready) begin
            if (cur.size() == 0) mord = l_shift;
            cur.push_back(int'(si));
         end
         if (cur.size() == D)
            model_complete();
`ifdef DESERIALIZER_FLUSH_EN
         else if (flush && cur.size() > 0)
            model_complete();
`endif
         tick;
      end

      si_valid = 1'b0; flush = 1'b0; po_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (po_valid) check_out("drain");
         tick;
      end
      chk("drain_empty", exp_word.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
